// File: rtl/f2_scaler.sv
// Maps the 640x480 display raster onto a 16x16 source image for f2_RAM lookup.
// Coordinates come from error accumulators and are only valid while locked to a clean raster.
module f2_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int SRC_W    = 16,
    parameter int SRC_H    = 16,
    parameter int CW       = 10,
    localparam int XIW     = $clog2(SRC_W),
    localparam int YIW     = $clog2(SRC_H)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pxl_en,
    input  logic [CW-1:0]  current_x,
    input  logic [CW-1:0]  current_y,
    output logic [XIW-1:0] actual_pxl_x,
    output logic [YIW-1:0] actual_pxl_y,
    output logic           pxl_valid,
    output logic           locked
);

    localparam int XEW = $clog2(H_ACTIVE + SRC_W);
    localparam int YEW = $clog2(V_ACTIVE + SRC_H);

    localparam logic [CW-1:0]  X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]  Y_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]  X_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0]  Y_ACT  = CW'(V_ACTIVE);
    localparam logic [XEW-1:0] X_STEP = XEW'(SRC_W);
    localparam logic [XEW-1:0] X_MOD  = XEW'(H_ACTIVE);
    localparam logic [YEW-1:0] Y_STEP = YEW'(SRC_H);
    localparam logic [YEW-1:0] Y_MOD  = YEW'(V_ACTIVE);
    localparam logic [XIW-1:0] X_MAX  = XIW'(SRC_W - 1);
    localparam logic [YIW-1:0] Y_MAX  = YIW'(SRC_H - 1);

    typedef enum logic {SEEK, RUN} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [1:0]     rst_sync;
    logic           arst_n;

    logic [CW-1:0]  prev_x;
    logic [CW-1:0]  prev_y;
    logic [CW-1:0]  exp_x;
    logic [CW-1:0]  exp_y;
    logic           origin;
    logic           match;

    logic [XEW-1:0] x_err;
    logic [XEW-1:0] x_err_nxt;
    logic [XEW-1:0] x_sum;
    logic [XIW-1:0] x_idx;
    logic [XIW-1:0] x_idx_nxt;
    logic [YEW-1:0] y_err;
    logic [YEW-1:0] y_err_nxt;
    logic [YEW-1:0] y_sum;
    logic [YIW-1:0] y_idx;
    logic [YIW-1:0] y_idx_nxt;

    logic [XIW-1:0] pxl_x_nxt;
    logic [YIW-1:0] pxl_y_nxt;
    logic           valid_nxt;
    logic           locked_nxt;

    // Reset asserts immediately but releases two clocks later, aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign arst_n = rst_sync[1];

    always_comb begin
        exp_x = prev_x + CW'(1);
        exp_y = prev_y;
        if (prev_x == X_LAST) begin
            exp_x = '0;
            exp_y = (prev_y == Y_LAST) ? '0 : prev_y + CW'(1);
        end
    end

    assign origin = (current_x == '0) && (current_y == '0);
    assign match  = (current_x == exp_x) && (current_y == exp_y);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= SEEK;
        end else if (pxl_en) begin
            state <= state_nxt;
        end
    end

    // A sample at (0,0) always (re)locks, even when it breaks the expected sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            SEEK: if (origin) state_nxt = RUN;
            RUN:  if (!match && !origin) state_nxt = SEEK;
            default: state_nxt = SEEK;
        endcase
    end

    always_comb begin
        x_err_nxt = x_err;
        x_idx_nxt = x_idx;
        y_err_nxt = y_err;
        y_idx_nxt = y_idx;
        x_sum     = x_err + X_STEP;
        y_sum     = y_err + Y_STEP;
        if (state_nxt != RUN) begin
            x_err_nxt = '0;
            x_idx_nxt = '0;
            y_err_nxt = '0;
            y_idx_nxt = '0;
        end else begin
            if (current_x == '0) begin
                x_err_nxt = '0;
                x_idx_nxt = '0;
            end else if (current_x < X_ACT) begin
                if (x_sum >= X_MOD) begin
                    x_err_nxt = x_sum - X_MOD;
                    if (x_idx != X_MAX) x_idx_nxt = x_idx + XIW'(1);
                end else begin
                    x_err_nxt = x_sum;
                end
            end
            // Rows advance once per line, on the first pixel of each new line.
            if (origin) begin
                y_err_nxt = '0;
                y_idx_nxt = '0;
            end else if ((current_x == '0) && (current_y < Y_ACT)) begin
                if (y_sum >= Y_MOD) begin
                    y_err_nxt = y_sum - Y_MOD;
                    if (y_idx != Y_MAX) y_idx_nxt = y_idx + YIW'(1);
                end else begin
                    y_err_nxt = y_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prev_x <= '0;
            prev_y <= '0;
            x_err  <= '0;
            x_idx  <= '0;
            y_err  <= '0;
            y_idx  <= '0;
        end else if (pxl_en) begin
            prev_x <= current_x;
            prev_y <= current_y;
            x_err  <= x_err_nxt;
            x_idx  <= x_idx_nxt;
            y_err  <= y_err_nxt;
            y_idx  <= y_idx_nxt;
        end
    end

    always_comb begin
        locked_nxt = (state_nxt == RUN);
        valid_nxt  = locked_nxt && (current_x < X_ACT) && (current_y < Y_ACT);
        pxl_x_nxt  = valid_nxt ? x_idx_nxt : '0;
        pxl_y_nxt  = valid_nxt ? y_idx_nxt : '0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            actual_pxl_x <= '0;
            actual_pxl_y <= '0;
            pxl_valid    <= 1'b0;
            locked       <= 1'b0;
        end else if (pxl_en) begin
            actual_pxl_x <= pxl_x_nxt;
            actual_pxl_y <= pxl_y_nxt;
            pxl_valid    <= valid_nxt;
            locked       <= locked_nxt;
        end
    end

endmodule
